// File: rtl/l1d_responder.sv
// l1d_responder: direct-mapped, write-back, write-allocate L1 data cache.
//   8 lines x 128 bits, 9-bit tag, valid and dirty bit per line.
//   Hits complete with zero wait states (mem_resp is combinational in IDLE).
//   A miss writes back a dirty victim first, then fills the line from pmem
//   and re-checks the request in IDLE, where it hits.
//
// Ports
//   clk, reset        sole clock; synchronous active-high reset
//   mem_*             CPU side: 16-bit byte address, read/write, 2 byte lanes
//   pmem_*            downstream side: 128-bit line read/write, pmem_resp done
//   hit_count,
//   miss_count        16-bit saturating performance counters
//
// Build option
//   L1D_PERF_EN       when defined, the hit/miss counters are implemented;
//                     when undefined they are tied to zero with no flops.
//
// state     | meaning
// ST_IDLE   | serve hits; on a miss pick WRITEBACK (dirty victim) or ALLOCATE
// ST_WRBACK | write the dirty victim line to pmem, wait for pmem_resp
// ST_ALLOC  | read the requested line from pmem, wait for pmem_resp, fill

module l1d_responder (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_wdata,
  output logic          mem_resp,
  output logic [15:0]   mem_rdata,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRBACK = 2'd1,
    ST_ALLOC  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [127:0] r_data [8];
  logic [8:0]   r_tag  [8];
  logic [7:0]   r_valid;
  logic [7:0]   r_dirty;

  logic [8:0]   w_tag;
  logic [2:0]   w_index;
  logic [2:0]   w_word;
  logic         w_unused_addr0;
  logic         w_req;
  logic         w_hit;
  logic         w_wr_hit;
  logic         w_miss_start;
  logic         w_wb_done;
  logic         w_fill;

  assign w_tag          = mem_address[15:7];
  assign w_index        = mem_address[6:4];
  assign w_word         = mem_address[3:1];
  assign w_unused_addr0 = mem_address[0];

  assign w_req        = mem_read | mem_write;
  assign w_hit        = (r_state == ST_IDLE) && w_req && r_valid[w_index]
                        && (r_tag[w_index] == w_tag);
  // read+write together is a write
  assign w_wr_hit     = w_hit && mem_write;
  assign w_miss_start = (r_state == ST_IDLE) && w_req && !w_hit;
  assign w_wb_done    = (r_state == ST_WRBACK) && pmem_resp;
  assign w_fill       = (r_state == ST_ALLOC) && pmem_resp;

  assign mem_resp   = w_hit;
  assign mem_rdata  = r_data[w_index][{w_word, 4'b0000} +: 16];
  assign pmem_wdata = r_data[w_index];

  always_comb begin
    w_state_nx   = r_state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {w_tag, w_index, 4'b0000};
    case (r_state)
      ST_IDLE: begin
        if (w_miss_start) begin
          if (r_valid[w_index] && r_dirty[w_index]) w_state_nx = ST_WRBACK;
          else                                      w_state_nx = ST_ALLOC;
        end
      end
      ST_WRBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[w_index], w_index, 4'b0000};
        if (pmem_resp) w_state_nx = ST_ALLOC;
      end
      ST_ALLOC: begin
        pmem_read = 1'b1;
        if (pmem_resp) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_wr_hit && (mem_byte_enable != 2'b00)) r_dirty[w_index] <= 1'b1;
      if (w_wb_done) r_dirty[w_index] <= 1'b0;
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_index] <= pmem_rdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_wr_hit) begin
      if (mem_byte_enable[0])
        r_data[w_index][{w_word, 4'b0000} +: 8] <= mem_wdata[7:0];
      if (mem_byte_enable[1])
        r_data[w_index][{w_word, 4'b1000} +: 8] <= mem_wdata[15:8];
    end
  end

`ifdef L1D_PERF_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != 16'hFFFF))
        r_hit_count <= r_hit_count + 16'd1;
      if (w_miss_start && (r_miss_count != 16'hFFFF))
        r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_l1d_responder.sv
// tb_l1d_responder: directed checks of l1d_responder against hand-computed
// values. Inputs change at posedge+1; outputs are sampled at posedge+4.
// A small downstream model answers pmem requests after a set latency.

module tb_l1d_responder;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [1:0]    mem_byte_enable;
  logic [15:0]   mem_wdata;
  logic          mem_resp;
  logic [15:0]   mem_rdata;
  logic [15:0]   pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [127:0]  pmem_wdata;
  logic [127:0]  pmem_rdata;
  logic          pmem_resp;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;

  int n_pass = 0;
  int n_total = 0;

  l1d_responder dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One CPU access, from posedge+1 to posedge+1 after the mem_resp cycle.
  task automatic cpu_access(
    input  logic [15:0]  addr,
    input  logic         rd,
    input  logic         wr,
    input  logic [1:0]   be,
    input  logic [15:0]  wd,
    input  logic [127:0] fill_line,
    input  int           lat,
    output logic [15:0]  rdata,
    output int           cycles,
    output int           n_wb,
    output int           n_rd,
    output logic [15:0]  wb_addr,
    output logic [127:0] wb_data,
    output logic [15:0]  rd_addr,
    output logic         both
  );
    int  wait_cnt;
    logic done;
    mem_address     = addr;
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    pmem_rdata      = fill_line;
    rdata = '0; cycles = 0; n_wb = 0; n_rd = 0;
    wb_addr = '0; wb_data = '0; rd_addr = '0; both = 1'b0;
    wait_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      #3;
      if (pmem_read && pmem_write) both = 1'b1;
      if (mem_resp) begin
        rdata = mem_rdata;
        done  = 1'b1;
      end else if (pmem_write) begin
        wb_addr = pmem_address;
        wb_data = pmem_wdata;
        wait_cnt++;
        if (wait_cnt >= lat) begin
          pmem_resp = 1'b1;
          n_wb++;
          wait_cnt = 0;
        end
      end else if (pmem_read) begin
        rd_addr = pmem_address;
        wait_cnt++;
        if (wait_cnt >= lat) begin
          pmem_resp = 1'b1;
          n_rd++;
          wait_cnt = 0;
        end
      end
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      cycles++;
    end
    chk("access_completes", done, 1'b1);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [127:0] L1 = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                 16'h3333, 16'h2222, 16'hBEEF, 16'h1111};
  localparam logic [127:0] L1W = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                  16'h3333, 16'h2222, 16'hBE34, 16'h1111};
  localparam logic [127:0] L2 = {16'h0707, 16'h0606, 16'h0505, 16'h0404,
                                 16'h0303, 16'h0202, 16'h0101, 16'hC0DE};
  localparam logic [127:0] L3 = {16'h3007, 16'h3006, 16'h3005, 16'h3004,
                                 16'h3003, 16'h3002, 16'h3001, 16'h3000};
  localparam logic [127:0] L4 = {16'h4007, 16'h4006, 16'h4005, 16'h4004,
                                 16'h4003, 16'h4002, 16'h4001, 16'h4000};

  logic [15:0]  rdata, wb_addr, rd_addr;
  logic [127:0] wb_data;
  logic         both;
  int           cycles, n_wb, n_rd;
  logic [15:0]  exp_hits, exp_misses;

  initial begin
    reset = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    #3;
    chk("rst_mem_resp", mem_resp, 1'b0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_hit_count", hit_count, 16'h0);
    chk("rst_miss_count", miss_count, 16'h0);
    @(posedge clk);
    #1;

    // cold read miss, 2-cycle downstream
    cpu_access(16'h0042, 1, 0, 2'b00, 16'h0, L1, 2, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("miss_rdata", rdata, 16'hBEEF);
    chk("miss_pmem_addr", rd_addr, 16'h0040);
    chk("miss_no_wb", n_wb, 0);
    chk("miss_fills", n_rd, 1);
    chk("miss_cycles", cycles, 4);
    chk("miss_no_both", both, 1'b0);

    cpu_access(16'h0046, 1, 0, 2'b00, 16'h0, '0, 2, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("hit_w3_rdata", rdata, 16'h3333);
    chk("hit_w3_cycles", cycles, 1);

    // byte-lane write hit
    cpu_access(16'h0042, 0, 1, 2'b01, 16'h1234, '0, 2, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("wr_hit_cycles", cycles, 1);
    cpu_access(16'h0042, 1, 0, 2'b00, 16'h0, '0, 2, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("wr_lane0_rdata", rdata, 16'hBE34);

    // write with no lanes enabled
    cpu_access(16'h0044, 0, 1, 2'b00, 16'hFFFF, '0, 2, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("wr_be00_cycles", cycles, 1);
    cpu_access(16'h0044, 1, 0, 2'b00, 16'h0, '0, 2, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("wr_be00_rdata", rdata, 16'h2222);

    // conflict miss with dirty victim
    cpu_access(16'h0840, 1, 0, 2'b00, 16'h0, L2, 2, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("wb_addr", wb_addr, 16'h0040);
    chk("wb_word1", wb_data[31:16], 16'hBE34);
    chk("wb_line", wb_data, L1W);
    chk("wb_count", n_wb, 1);
    chk("wb_alloc_addr", rd_addr, 16'h0840);
    chk("wb_rdata", rdata, 16'hC0DE);
    chk("wb_cycles", cycles, 6);
    chk("wb_no_both", both, 1'b0);

    // reset in the middle of ALLOCATE
    mem_address = 16'h0100; mem_read = 1'b1; pmem_rdata = L3;
    #3;
    chk("abort_miss_resp", mem_resp, 1'b0);
    @(posedge clk);
    #4;
    chk("abort_in_alloc", pmem_read, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #4;
    chk("abort_pmem_read", pmem_read, 1'b0);
    chk("abort_pmem_write", pmem_write, 1'b0);
    chk("abort_mem_resp", mem_resp, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0; mem_read = 1'b0;
    cpu_access(16'h0100, 1, 0, 2'b00, 16'h0, L3, 1, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("abort_remiss_cycles", cycles, 3);
    chk("abort_remiss_fill", n_rd, 1);
    chk("abort_remiss_rdata", rdata, 16'h3000);

    // read and write together behave as a write
    cpu_access(16'h0102, 1, 1, 2'b11, 16'hABCD, '0, 1, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("rw_cycles", cycles, 1);
    cpu_access(16'h0102, 1, 0, 2'b00, 16'h0, '0, 1, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("rw_rdata", rdata, 16'hABCD);
    cpu_access(16'h0200, 1, 0, 2'b00, 16'h0, L4, 1, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("rw_dirty_wb", n_wb, 1);
    chk("rw_wb_addr", wb_addr, 16'h0100);
    chk("rw_wb_word1", wb_data[31:16], 16'hABCD);
    chk("rw_rdata_new", rdata, 16'h4000);

    // clean victim skips writeback
    cpu_access(16'h0100, 1, 0, 2'b00, 16'h0, L3, 1, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    chk("clean_no_wb", n_wb, 0);
    chk("clean_cycles", cycles, 3);

    // performance counters: 3 hits, 2 misses
    do_reset();
    cpu_access(16'h0300, 1, 0, 2'b00, 16'h0, L4, 1, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    cpu_access(16'h0300, 1, 0, 2'b00, 16'h0, '0, 1, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    cpu_access(16'h0310, 1, 0, 2'b00, 16'h0, L3, 1, rdata, cycles, n_wb, n_rd,
               wb_addr, wb_data, rd_addr, both);
    #3;
`ifdef L1D_PERF_EN
    exp_hits = 16'd3; exp_misses = 16'd2;
`else
    exp_hits = 16'd0; exp_misses = 16'd0;
`endif
    chk("perf_hit_count", hit_count, exp_hits);
    chk("perf_miss_count", miss_count, exp_misses);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l1d_responder.md
L1D_RESPONDER -- requirements
Module: l1d_responder

Interface
REQ-001 SHALL expose: clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL expose: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: mem_address  input  16  CPU byte address; tag [15:7], index [6:4], word [3:1].
REQ-004 SHALL expose: mem_read  input  1  CPU read request, held until mem_resp.
REQ-005 SHALL expose: mem_write  input  1  CPU write request, held until mem_resp.
REQ-006 SHALL expose: mem_byte_enable  input  2  write lanes; bit0 = [7:0], bit1 = [15:8].
REQ-007 SHALL expose: mem_wdata  input  16  CPU write data.
REQ-008 SHALL expose: mem_resp  output  1  one-cycle completion strobe to CPU.
REQ-009 SHALL expose: mem_rdata  output  16  read word; valid when mem_resp=1.
REQ-010 SHALL expose: pmem_address  output  16  line-aligned address, bits [3:0] = 0.
REQ-011 SHALL expose: pmem_read / pmem_write  output  1 each  downstream line requests.
REQ-012 SHALL expose: pmem_wdata  output  128  evicted line; pmem_rdata  input  128  fill line; pmem_resp  input  1  downstream done.
REQ-013 SHALL expose: hit_count, miss_count  output  16 each  performance counters (see Configuration).

Function
REQ-014 SHALL be a direct-mapped, write-back, write-allocate cache: 8 lines of 128 bits, each with a 9-bit tag, a valid bit and a dirty bit.
REQ-015 SHALL implement FSM states IDLE, WRITEBACK and ALLOCATE; reset state IDLE.
REQ-016 IDLE: hit = request active AND valid[index] AND tag match; on hit assert mem_resp combinationally in the same cycle (zero wait states).
REQ-017 Read hit: mem_rdata SHALL equal word [3:1] of the indexed line; mem_rdata always drives the selected word regardless of mem_resp.
REQ-018 Write hit: SHALL update only the enabled byte lanes at the clock edge and set dirty[index]; mem_byte_enable = 00 completes with no data change and no dirty update.
REQ-019 mem_read and mem_write both high SHALL be treated as a write.
REQ-020 IDLE miss with dirty victim SHALL go to WRITEBACK; miss with clean or invalid victim SHALL go to ALLOCATE; no mem_resp on a miss cycle.
REQ-021 WRITEBACK: pmem_write=1, pmem_address={stored tag, index, 4'b0}, pmem_wdata=victim line; on pmem_resp clear dirty and go to ALLOCATE.
REQ-022 ALLOCATE: pmem_read=1, pmem_address={request tag, index, 4'b0}; on pmem_resp write pmem_rdata, tag and valid, clear dirty, and return to IDLE.
REQ-023 After a fill, the request SHALL hit in the next IDLE cycle, giving miss latency = downstream latency + 1 cycle.
REQ-024 pmem_read and pmem_write SHALL never be high together; both SHALL be 0 in IDLE.
REQ-025 CPU inputs SHALL be stable while the FSM is outside IDLE; a request dropped mid-miss SHALL still complete the fill and then idle.

Reset
REQ-026 Reset SHALL clear all valid and dirty bits, set the state to IDLE, and drive mem_resp, pmem_read and pmem_write to 0 the cycle after assertion.
REQ-027 Reset during WRITEBACK or ALLOCATE SHALL abandon the transaction; dirty data in flight is lost. Data and tag arrays are not reset.
REQ-028 Reset SHALL zero hit_count and miss_count.

Configuration
REQ-029 Macro L1D_PERF_EN defined: hit_count increments on each IDLE hit cycle with mem_resp; miss_count increments once per miss on the IDLE-to-WRITEBACK/ALLOCATE transition. Both counters saturate at 0xFFFF.
REQ-030 Macro L1D_PERF_EN undefined: hit_count and miss_count SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-031 After reset, read 0x0042 with pmem_rdata word1 = 0xBEEF and 2-cycle pmem_resp -> pmem_read at address 0x0040, then mem_resp with mem_rdata = 0xBEEF; no pmem_write.
REQ-032 Write 0x0042 with wdata 0x1234, byte_enable 01 on a line holding 0xBEEF -> same-cycle mem_resp; a following read returns 0xBE34.
REQ-033 Dirty line at tag for 0x0040, then read 0x0840 -> WRITEBACK to 0x0040 with pmem_wdata word1 = 0xBE34, then ALLOCATE at 0x0840, then mem_resp.
REQ-034 Assert reset during ALLOCATE -> pmem_read = 0 next cycle; a following read of the same address misses again.
REQ-035 With L1D_PERF_EN, 3 hits and 2 misses -> hit_count = 3, miss_count = 2 (the post-fill hit counts); without the macro both read 0.
REQ-036 Simultaneous mem_read and mem_write to a hit line -> data written, dirty set, single mem_resp.
